// File: rtl/stream_pkg.sv
// Shared definitions for the 32-bit ready/valid stream blocks.
package stream_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned SUM_W_DEF  = 32;

    // A beat moves across a ready/valid interface when both sides agree.
    function automatic logic xfer(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// One-entry ready/valid output register with a load port and a full flag.
// The load port is only honoured when the caller knows the slot is free or draining.
module stream_out_reg
    import stream_pkg::*;
#(
    parameter int unsigned W = SUM_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         full
);

    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         out_xfer;

    assign out_xfer  = xfer(valid_q, out_ready);
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign full      = valid_q;

    // Load wins over drain so a new value can replace the one leaving this cycle.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end else if (out_xfer) begin
            valid_d = 1'b0;
        end
    end

    // Register state; data is held untouched while valid waits for ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/stream_block_sum.sv
// Sums each run of BLOCK_LEN accepted input words and emits one sum per block.
module stream_block_sum
    import stream_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned SUM_W     = SUM_W_DEF,
    parameter int unsigned BLOCK_LEN = 100,
    parameter int unsigned CNT_W     = $clog2(BLOCK_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] input_fifo,
    input  logic              input_fifo_valid,
    output logic              input_fifo_ready,
    output logic [SUM_W-1:0]  output_fifo,
    output logic              output_fifo_valid,
    input  logic              output_fifo_ready,
    output logic [31:0]       blocks_done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

    logic [SUM_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      blocks_done_q, blocks_done_d;

    logic [SUM_W-1:0] word_ext;
    logic [SUM_W-1:0] sum_next;
    logic             is_final;
    logic             out_full;
    logic             in_xfer;
    logic             out_xfer;
    logic             load;

    // Zero-extends or truncates, depending on the relative widths.
    assign word_ext = SUM_W'(input_fifo);
    assign sum_next = acc_q + word_ext;
    assign is_final = (cnt_q == LAST_CNT);

    // Only the final word needs the output slot; stall it if the slot is
    // occupied and not draining this cycle. No dependence on input valid.
    assign input_fifo_ready = !(is_final && out_full && !output_fifo_ready);

    assign in_xfer  = xfer(input_fifo_valid, input_fifo_ready);
    assign out_xfer = xfer(output_fifo_valid, output_fifo_ready);

    // Accumulate non-final words; on the final word hand off the sum and restart.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        load  = 1'b0;
        if (in_xfer) begin
            if (is_final) begin
                acc_d = '0;
                cnt_d = '0;
                load  = 1'b1;
            end else begin
                acc_d = sum_next;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Count sums accepted downstream.
    always_comb begin
        blocks_done_d = blocks_done_q;
        if (out_xfer) begin
            blocks_done_d = blocks_done_q + 32'd1;
        end
    end

    // Block state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q         <= '0;
            cnt_q         <= '0;
            blocks_done_q <= '0;
        end else begin
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            blocks_done_q <= blocks_done_d;
        end
    end

    assign blocks_done = blocks_done_q;

    stream_out_reg #(
        .W (SUM_W)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (sum_next),
        .out_data  (output_fifo),
        .out_valid (output_fifo_valid),
        .out_ready (output_fifo_ready),
        .full      (out_full)
    );

endmodule

// File: tb/tb_stream_block_sum.sv
// Directed bench for stream_block_sum: BLOCK_LEN=100 streams and BLOCK_LEN=1 edges.
module tb_stream_block_sum;

    logic        clk;
    logic        rst_n;

    // BLOCK_LEN = 100 instance
    logic [31:0] a_data;
    logic        a_valid;
    logic        a_in_ready;
    logic [31:0] a_odata;
    logic        a_ovalid;
    logic        a_oready;
    logic [31:0] a_done;

    // BLOCK_LEN = 1 instance
    logic [31:0] b_data;
    logic        b_valid;
    logic        b_in_ready;
    logic [31:0] b_odata;
    logic        b_ovalid;
    logic        b_oready;
    logic [31:0] b_done;

    int n_checks;
    int n_fail;

    stream_block_sum #(
        .BLOCK_LEN (100)
    ) dut_a (
        .clk               (clk),
        .reset             (rst_n),
        .input_fifo        (a_data),
        .input_fifo_valid  (a_valid),
        .input_fifo_ready  (a_in_ready),
        .output_fifo       (a_odata),
        .output_fifo_valid (a_ovalid),
        .output_fifo_ready (a_oready),
        .blocks_done       (a_done)
    );

    stream_block_sum #(
        .BLOCK_LEN (1)
    ) dut_b (
        .clk               (clk),
        .reset             (rst_n),
        .input_fifo        (b_data),
        .input_fifo_valid  (b_valid),
        .input_fifo_ready  (b_in_ready),
        .output_fifo       (b_odata),
        .output_fifo_valid (b_ovalid),
        .output_fifo_ready (b_oready),
        .blocks_done       (b_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor for instance A: collects sums and protocol observations.
    logic [31:0] sums[$];
    int          in_acc;
    int          cyc;
    int          stall_cnt;
    int          drop_err;
    int          stable_err;
    int          w99_cyc;
    int          vrise_cyc;
    logic        v_seen;
    logic        prev_stall;
    logic [31:0] prev_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sums.delete();
            in_acc     <= 0;
            cyc        <= 0;
            stall_cnt  <= 0;
            drop_err   <= 0;
            stable_err <= 0;
            w99_cyc    <= -10;
            vrise_cyc  <= -1;
            v_seen     <= 1'b0;
            prev_stall <= 1'b0;
            prev_data  <= '0;
        end else begin
            cyc <= cyc + 1;
            if (a_valid && a_in_ready) begin
                in_acc <= in_acc + 1;
                if (in_acc == 99) w99_cyc <= cyc;
            end
            if (a_valid && !a_in_ready) stall_cnt <= stall_cnt + 1;
            if (!a_in_ready && ((in_acc % 100) != 99)) drop_err <= drop_err + 1;
            if (prev_stall && (!a_ovalid || a_odata != prev_data)) stable_err <= stable_err + 1;
            prev_stall <= a_ovalid && !a_oready;
            prev_data  <= a_odata;
            if (a_ovalid && !v_seen) begin
                v_seen    <= 1'b1;
                vrise_cyc <= cyc;
            end
            if (a_ovalid && a_oready) sums.push_back(a_odata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        a_valid  = 1'b0;
        a_oready = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("rst_ovalid", {31'd0, a_ovalid}, 32'd0);
        chk("rst_odata", a_odata, 32'd0);
        chk("rst_done", a_done, 32'd0);
        chk("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Streams `total` words (value = index, or all ones) and waits for `nexp` sums.
    task automatic run_stream(input int total, input int nexp, input bit gate, input bit bp,
                              input bit allones);
        int  start;
        int  n;
        int  drove;
        int  hold;
        int  budget;
        bit  pend;
        start  = in_acc;
        drove  = -1;
        hold   = 0;
        budget = 0;
        while (((in_acc - start) < total || sums.size() < nexp) && budget < 6000) begin
            @(negedge clk);
            budget++;
            if (bp) begin
                if (hold > 0) begin
                    a_oready = 1'b0;
                    hold--;
                end else begin
                    a_oready = 1'b1;
                    if (a_ovalid) hold = 5;
                end
            end else begin
                a_oready = 1'b1;
            end
            n    = in_acc - start;
            pend = a_valid && (n == drove);
            if (!pend) begin
                if (n < total) begin
                    a_valid = gate ? ($urandom_range(0, 1) == 1) : 1'b1;
                    a_data  = allones ? 32'hFFFF_FFFF : 32'(n);
                    drove   = n;
                end else begin
                    a_valid = 1'b0;
                end
            end
        end
        chk("no_timeout", {31'd0, budget < 6000}, 32'd1);
        @(negedge clk);
        a_valid  = 1'b0;
        a_oready = 1'b1;
    endtask

    task automatic chk_ten_sums();
        chk("n_sums", 32'(sums.size()), 32'd10);
        for (int k = 0; k < 10; k++) begin
            chk("sum", (k < sums.size()) ? sums[k] : 32'hx, 32'(4950 + 10000 * k));
        end
        chk("blocks_done", a_done, 32'd10);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        a_data   = '0;
        a_valid  = 1'b0;
        a_oready = 1'b1;
        b_data   = '0;
        b_valid  = 1'b0;
        b_oready = 1'b1;

        do_reset();
        chk("b_rst_ovalid", {31'd0, b_ovalid}, 32'd0);
        chk("b_rst_ready", {31'd0, b_in_ready}, 32'd1);

        // BLOCK_LEN=1: 7,8,9 back to back with ready high.
        @(negedge clk);
        b_valid = 1'b1;
        b_data  = 32'd7;
        @(negedge clk);
        chk("b_v7", {31'd0, b_ovalid}, 32'd1);
        chk("b_d7", b_odata, 32'd7);
        b_data = 32'd8;
        @(negedge clk);
        chk("b_d8", b_odata, 32'd8);
        b_data = 32'd9;
        @(negedge clk);
        chk("b_d9", b_odata, 32'd9);
        b_valid = 1'b0;
        @(negedge clk);
        chk("b_v_off", {31'd0, b_ovalid}, 32'd0);
        chk("b_done3", b_done, 32'd3);

        // BLOCK_LEN=1 backpressure: final word stalls while slot is full.
        b_oready = 1'b0;
        b_valid  = 1'b1;
        b_data   = 32'd5;
        @(negedge clk);
        chk("b_d5", b_odata, 32'd5);
        chk("b_stall", {31'd0, b_in_ready}, 32'd0);
        b_data = 32'd6;
        @(negedge clk);
        chk("b_hold5", b_odata, 32'd5);
        chk("b_stall2", {31'd0, b_in_ready}, 32'd0);
        b_oready = 1'b1;
        #1;
        chk("b_ready_comb", {31'd0, b_in_ready}, 32'd1);
        @(negedge clk);
        chk("b_d6", b_odata, 32'd6);
        chk("b_done4", b_done, 32'd4);
        b_valid = 1'b0;
        @(negedge clk);
        chk("b_v_off2", {31'd0, b_ovalid}, 32'd0);
        chk("b_done5", b_done, 32'd5);

        // Continuous stream, ready always high.
        do_reset();
        run_stream(1000, 10, 1'b0, 1'b0, 1'b0);
        chk_ten_sums();
        chk("latency", 32'(vrise_cyc), 32'(w99_cyc + 1));
        chk("no_stalls", 32'(stall_cnt), 32'd0);
        chk("ovalid_idle", {31'd0, a_ovalid}, 32'd0);

        // Downstream ready low for 5 cycles after each sum.
        do_reset();
        run_stream(1000, 10, 1'b0, 1'b1, 1'b0);
        chk_ten_sums();
        chk("ready_drop_only_last", 32'(drop_err), 32'd0);
        chk("stable_while_stalled", 32'(stable_err), 32'd0);

        // Input valid gated at 50%.
        do_reset();
        run_stream(1000, 10, 1'b1, 1'b0, 1'b0);
        chk_ten_sums();

        // All-ones words wrap to 0xFFFFFF9C per block.
        do_reset();
        run_stream(200, 2, 1'b0, 1'b0, 1'b1);
        chk("ones_n", 32'(sums.size()), 32'd2);
        chk("ones_s0", (sums.size() > 0) ? sums[0] : 32'hx, 32'hFFFF_FF9C);
        chk("ones_s1", (sums.size() > 1) ? sums[1] : 32'hx, 32'hFFFF_FF9C);

        // Reset after word 57 of the second block, then a fresh block.
        do_reset();
        run_stream(158, 1, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_n", 32'(sums.size()), 32'd1);
        chk("pre_rst_done", a_done, 32'd1);
        do_reset();
        run_stream(100, 1, 1'b0, 1'b0, 1'b0);
        chk("post_rst_n", 32'(sums.size()), 32'd1);
        chk("post_rst_sum", (sums.size() > 0) ? sums[0] : 32'hx, 32'd4950);
        chk("post_rst_done", a_done, 32'd1);
        repeat (3) @(negedge clk);
        chk("no_stale", {31'd0, a_ovalid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
